// File: rtl/pkt_ram_arbiter.sv
// Round-robin arbiter sharing the pkt_ram read port between NUM_REQ burst readers.
// One accepted burst owns the RAM address port until its last word has returned.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module pkt_ram_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_last,
    output logic [ADDR_WIDTH-1:0]         ram_addr_o,
    input  logic [DATA_WIDTH-1:0]         ram_data_i,
    output logic                          busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     owner;
    logic [IDX_W-1:0]     winner;
    logic                 found;
    logic [LEN_WIDTH-1:0] remaining;
    logic [LEN_WIDTH-1:0] win_len;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [IDX_W-1:0]     next_ptr;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                found  = 1'b1;
                winner = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign win_addr  = req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_len   = req_len[int'(winner)*LEN_WIDTH +: LEN_WIDTH];
    assign next_ptr  = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
    assign req_ready = (rst && found && state == IDLE) ? (NUM_REQ'(1) << winner) : '0;
    assign busy      = (state != IDLE);
    assign rsp_data  = ram_data_i;

    // ram_addr_o doubles as the running burst address, so it naturally holds outside BURST.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            remaining  <= '0;
            ram_addr_o <= '0;
            rsp_valid  <= '0;
            rsp_last   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            rsp_last  <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        owner      <= winner;
                        ram_addr_o <= win_addr;
                        remaining  <= (win_len == '0) ? LEN_WIDTH'(1) : win_len;
                        rr_ptr     <= next_ptr;
                        state      <= BURST;
                    end
                end
                BURST: begin
                    rsp_valid <= NUM_REQ'(1) << owner;
                    remaining <= remaining - LEN_WIDTH'(1);
                    if (remaining == LEN_WIDTH'(1)) begin
                        rsp_last <= 1'b1;
                        state    <= DRAIN;
                    end else begin
                        ram_addr_o <= ram_addr_o + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
